// File: rtl/maxpool_window_2x2_if.sv
// Handshake bundle between the pixel stream, the 2x2 window generator and the max-pool comparator.
// master drives pixels and observes windows; slave is the window generator side.
`timescale 1ns/1ps
interface maxpool_window_2x2_if #(
  parameter int DATA_WIDHT = 32
);
  logic [DATA_WIDHT-1:0] Data_In;
  logic                  Valid_In;
  logic [DATA_WIDHT-1:0] Data_A;
  logic [DATA_WIDHT-1:0] Data_B;
  logic [DATA_WIDHT-1:0] Data_C;
  logic [DATA_WIDHT-1:0] Data_D;
  logic                  Valid_Out;
  logic                  Frame_Done;

  modport master (
    output Data_In, Valid_In,
    input  Data_A, Data_B, Data_C, Data_D, Valid_Out, Frame_Done
  );

  modport slave (
    input  Data_In, Valid_In,
    output Data_A, Data_B, Data_C, Data_D, Valid_Out, Frame_Done
  );
endinterface

// File: rtl/maxpool_window_2x2.sv
// Streaming 2x2 stride-2 window generator: buffers one even row, emits A/B/C/D on odd-row odd-col pixels.
// Optional fused input ReLU (negative words forced to zero) when MAXPOOL_WIN_RELU_EN is defined.
`timescale 1ns/1ps
module maxpool_window_2x2 #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                 clk,
  input  logic                 rst,
  maxpool_window_2x2_if.slave  bus
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);

  typedef enum logic {FILL, EMIT} state_t;

  state_t                r_state;
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic [DATA_WIDHT-1:0] r_left;
  logic [DATA_WIDHT-1:0] r_lineBuf [IMG_WIDTH];
  logic [DATA_WIDHT-1:0] r_dataA, r_dataB, r_dataC, r_dataD;
  logic                  r_validOut;
  logic                  r_frameDone;

  logic [DATA_WIDHT-1:0] w_pix;
  logic                  w_lastCol;
  logic                  w_lastRow;

`ifdef MAXPOOL_WIN_RELU_EN
  assign w_pix = bus.Data_In[DATA_WIDHT-1] ? '0 : bus.Data_In;
`else
  assign w_pix = bus.Data_In;
`endif

  assign w_lastCol = (r_col == LAST_COL);
  assign w_lastRow = (r_row == LAST_ROW);

  // A trailing even row of an odd-height frame stays in FILL so it is never windowed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= FILL;
      r_col       <= '0;
      r_row       <= '0;
      r_left      <= '0;
      r_dataA     <= '0;
      r_dataB     <= '0;
      r_dataC     <= '0;
      r_dataD     <= '0;
      r_validOut  <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_validOut  <= 1'b0;
      r_frameDone <= 1'b0;
      if (bus.Valid_In) begin
        r_frameDone <= w_lastCol && w_lastRow;
        if (w_lastCol) begin
          r_col <= '0;
          r_row <= w_lastRow ? '0 : r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
        case (r_state)
          FILL: begin
            if (w_lastCol && !w_lastRow) r_state <= EMIT;
          end
          EMIT: begin
            if (!r_col[0]) begin
              r_left <= w_pix;
            end else begin
              r_dataA    <= r_lineBuf[r_col - CW'(1)];
              r_dataB    <= r_lineBuf[r_col];
              r_dataC    <= r_left;
              r_dataD    <= w_pix;
              r_validOut <= 1'b1;
            end
            if (w_lastCol) r_state <= FILL;
          end
          default: r_state <= FILL;
        endcase
      end
    end
  end

  // Row buffer is never reset: every entry is rewritten during FILL before EMIT reads it.
  always_ff @(posedge clk) begin
    if (bus.Valid_In && (r_state == FILL)) r_lineBuf[r_col] <= w_pix;
  end

  assign bus.Data_A     = r_dataA;
  assign bus.Data_B     = r_dataB;
  assign bus.Data_C     = r_dataC;
  assign bus.Data_D     = r_dataD;
  assign bus.Valid_Out  = r_validOut;
  assign bus.Frame_Done = r_frameDone;

endmodule

// File: doc/maxpool_window_2x2.md
# maxpool_window_2x2

Streaming window generator directly upstream of the 2x2 max-pooling comparator. It accepts one feature-map word per valid cycle in raster order (row-major, one channel) and buffers one even row. On every odd-row, odd-column pixel it emits the four words of a non-overlapping 2x2, stride-2 window on parallel outputs A/B/C/D for the comparator. Frame position is tracked with row/column counters, and a frame-done pulse is raised on the last pixel.

## Interface
- `DATA_WIDHT`, 32: word width (IEEE-754 single; only the sign bit is interpreted, and only under the macro).
- `IMG_WIDTH`, 28: pixels per row, ≥2.
- `IMG_HEIGHT`, 28: rows per frame, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `Data_In`  in  DATA_WIDHT  input pixel.
- `Valid_In`  in  1  `Data_In` is accepted on this edge; no back-pressure.
- `Data_A`  out  DATA_WIDHT  window top-left (row r-1, col c-1).
- `Data_B`  out  DATA_WIDHT  window top-right (row r-1, col c).
- `Data_C`  out  DATA_WIDHT  window bottom-left (row r, col c-1).
- `Data_D`  out  DATA_WIDHT  window bottom-right (row r, col c).
- `Valid_Out`  out  1  one-cycle pulse; A–D hold a new window.
- `Frame_Done`  out  1  one-cycle pulse, coincident with the last accepted pixel of a frame.

## Operation
- Counters:
  - `col` is 0..IMG_WIDTH-1 and `row` is 0..IMG_HEIGHT-1, each $clog2 wide.
  - Both advance only on accepted pixels.
  - `col` wraps to 0 at IMG_WIDTH-1 and increments `row`; `row` wraps to 0 at IMG_HEIGHT-1, starting the next frame.
- FSM, two states:
  - FILL (even row): an accepted pixel is written to `line_buf[col]`.
  - EMIT (odd row):
    - At even `col`, the pixel is stored in the `left` register.
    - At odd `col`, the window is registered: A=`line_buf[col-1]`, B=`line_buf[col]`, C=`left`, D=`Data_In`, and `Valid_Out` pulses.
  - Transitions: FILL→EMIT on an accepted pixel at `col`=IMG_WIDTH-1. EMIT→FILL on an accepted pixel at `col`=IMG_WIDTH-1.
- Odd IMG_WIDTH: the last column is accepted and counted but never windowed; the output is floor(W/2) windows per row pair.
- Odd IMG_HEIGHT: the last row is treated as FILL and never emitted; the output is floor(H/2) window rows.
- Windows per frame = floor(W/2)·floor(H/2).
- `line_buf` is an IMG_WIDTH-deep register array or distributed RAM. Its contents are not reset and are always rewritten before they are read.
- Gaps: `Valid_In`=0 freezes all state. Gaps of any length, anywhere (mid-row, mid-window, between frames), must not alter the window contents or their order.
- A–D hold their last window until the next one is emitted.

## Timing
- Reset, asynchronous (any time, including mid-frame):
  - `col`=0, `row`=0, state FILL, `left`=0.
  - A/B/C/D=0, `Valid_Out`=0, `Frame_Done`=0.
  - The first pixel accepted after release is pixel (0,0) of a new frame.
- Latency: `Valid_Out` is high in the cycle after the edge that accepts pixel (odd row, odd col), and it carries that pixel as D.
- `Valid_Out` is never high on two consecutive cycles unless two emitting pixels are accepted back-to-back, which is impossible for stride 2. The maximum output rate is therefore one window per 2 accepted pixels.
- `Frame_Done`: registered; high in the cycle after acceptance of (IMG_HEIGHT-1, IMG_WIDTH-1).
  - For even W and H it coincides with the last `Valid_Out`.
  - A new frame's (0,0) may be accepted on that same edge; no idle cycle is needed.
- Downstream interaction: the comparator samples A–D while `Valid_Out` is high. A–D stay stable for at least two cycles at full input rate.

## Configuration
- Macro `MAXPOOL_WIN_RELU_EN`.
- Defined: fused ReLU at the input. A word with sign bit (bit DATA_WIDHT-1) = 1 is replaced by all-zeros before it is stored in `line_buf`/`left` or placed on D. This applies to -0.0 and to negative NaNs.
- Undefined: words pass through bit-exact and no sign logic is synthesized.

## Test plan
- 4x4 frame, pixels 1.0..16.0, continuous valid → exactly 4 `Valid_Out` pulses, with (A,B,C,D) = (1,2,5,6), (3,4,7,8), (9,10,13,14), (11,12,15,16). `Frame_Done` fires one cycle after pixel 16 is accepted.
- Same 4x4 frame with pseudo-random `Valid_In` gaps of 0–5 cycles → identical window sequence. A–D are stable between pulses.
- 5x3 frame (odd width and height), pixels 1..15 → 2 windows, (1,2,6,7) and (3,4,8,9). Column 4 and row 2 produce nothing. `Frame_Done` follows pixel 15.
- Reset asserted after 6 pixels of a 4x4 frame, then a full 4x4 frame of 1..16 → outputs are zero during reset, and only the 4 correct windows of the new frame appear.
- Two back-to-back 4x4 frames with no gap → 8 windows in order. The second frame's first window is (1,2,5,6).
- With `MAXPOOL_WIN_RELU_EN`, 2x2 frame {-3.0, 2.0, -0.0, -1.0} → one window (0,2.0,0,0). Without the macro → (-3.0, 2.0, -0.0, -1.0) bit-exact.
